// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory request/response bus between the LSU and memory.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
                  input  dmem_ready, dmem_rvalid, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
                  output dmem_ready, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer with lane steering and load extension.
module load_store_unit (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_load,
  input  logic             is_store,
  input  logic [1:0]       mem_width,
  input  logic             mem_unsigned,
  input  logic [31:0]      addr,
  input  logic [31:0]      store_data,
  load_store_unit_if.master dmem,
  output logic             busy,
  output logic             done,
  output logic [31:0]      load_data,
  output logic             misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, FIN} state_t;
  state_t state_q, state_d;
  logic load_q, load_d, uns_q, uns_d, mis_q, mis_d;
  logic [1:0] width_q, width_d, lane_q, lane_d;
  logic req_q, req_d, we_q, we_d, busy_q, busy_d, done_q, done_d, mis_out_q, mis_out_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d, shifted;
  logic [3:0] wstrb_q, wstrb_d;
  logic accept, bad, wr;
  assign accept = state_q == IDLE && start;
  assign bad = (mem_width == 2'b01 && addr[0]) || (mem_width[1] && addr[1:0] != 2'b00);
  // a load takes priority if both op kinds are flagged
  assign wr = is_store && !is_load;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (!(is_load || is_store) || bad) ? FIN : REQ;
      REQ:  if (dmem.dmem_ready) state_d = load_q ? RESP : FIN;
      RESP: if (dmem.dmem_rvalid) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    load_d = accept ? is_load : load_q;
    uns_d = accept ? mem_unsigned : uns_q;
    width_d = accept ? mem_width : width_q;
    lane_d = accept ? addr[1:0] : lane_q;
    mis_d = accept ? (is_load || is_store) && bad : mis_q;
    addr_d = accept ? {addr[31:2], 2'b00} : addr_q;
    we_d = accept ? wr : we_q;
    wdata_d = !accept ? wdata_q :
              mem_width == 2'b00 ? {4{store_data[7:0]}} :
              mem_width == 2'b01 ? {2{store_data[15:0]}} : store_data;
    wstrb_d = !accept ? wstrb_q : !wr ? 4'b0000 :
              mem_width == 2'b00 ? 4'b0001 << addr[1:0] :
              mem_width == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    req_d = state_d == REQ;
    busy_d = state_d != IDLE;
    done_d = state_q == FIN;
    mis_out_d = state_q == FIN && mis_q;
    shifted = dmem.dmem_rdata >> {lane_q, 3'b000};
    ld_d = !(state_q == RESP && dmem.dmem_rvalid) ? ld_q :
           width_q == 2'b00 ? {{24{!uns_q && shifted[7]}}, shifted[7:0]} :
           width_q == 2'b01 ? {{16{!uns_q && shifted[15]}}, shifted[15:0]} : dmem.dmem_rdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      load_q <= 1'b0;
      uns_q <= 1'b0;
      width_q <= 2'b00;
      lane_q <= 2'b00;
      mis_q <= 1'b0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      req_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mis_out_q <= 1'b0;
      ld_q <= '0;
    end else begin
      load_q <= load_d;
      uns_q <= uns_d;
      width_q <= width_d;
      lane_q <= lane_d;
      mis_q <= mis_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      req_q <= req_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mis_out_q <= mis_out_d;
      ld_q <= ld_d;
    end
  assign dmem.dmem_req = req_q;
  assign dmem.dmem_we = we_q;
  assign dmem.dmem_addr = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;
  assign busy = busy_q;
  assign done = done_q;
  assign misaligned = mis_out_q;
  assign load_data = ld_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit with a simple memory responder.
module tb_load_store_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_load = 1'b0, is_store = 1'b0, mem_unsigned = 1'b0;
  logic [1:0] mem_width = 2'b00;
  logic [31:0] addr = '0, store_data = '0;
  logic busy, done, misaligned;
  logic [31:0] load_data;
  int checks = 0, errors = 0;
  logic [31:0] ld_hist = '0;
  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mis;
    logic [31:0] ld;
    int          lat;
  } exp_t;
  exp_t sb[$];
  load_store_unit_if dif();
  load_store_unit dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .mem_width(mem_width), .mem_unsigned(mem_unsigned), .addr(addr), .store_data(store_data),
    .dmem(dif), .busy(busy), .done(done), .load_data(load_data), .misaligned(misaligned)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [1:0] w,
                        input logic uns, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int rdy_dly, input logic spur, input logic restart);
    exp_t e, g;
    int cyc, nreq, sh, lat_obs;
    logic acc;
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] ext;
    e.mis = (ld || st) && ((w == 2'b01 && a[0]) || (w[1] && a[1:0] != 2'b00));
    e.req = (ld || st) && !e.mis;
    e.we = st && !ld;
    e.daddr = {a[31:2], 2'b00};
    case (w)
      2'b00: begin e.wdata = {4{sd[7:0]}}; e.wstrb = 4'b0001 << a[1:0]; end
      2'b01: begin e.wdata = {2{sd[15:0]}}; e.wstrb = a[1] ? 4'b1100 : 4'b0011; end
      default: begin e.wdata = sd; e.wstrb = 4'b1111; end
    endcase
    if (!e.we) e.wstrb = 4'b0000;
    sh = 8 * int'(a[1:0]);
    b = rd[sh +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    ext = w == 2'b00 ? (uns ? {24'b0, b} : {{24{b[7]}}, b}) :
          w == 2'b01 ? (uns ? {16'b0, h} : {{16{h[15]}}, h}) : rd;
    if (ld && e.req) ld_hist = ext;
    e.ld = ld_hist;
    e.lat = !e.req ? 2 : e.we ? 3 + rdy_dly : 4 + rdy_dly;
    sb.push_back(e);
    is_load = ld; is_store = st; mem_width = w; mem_unsigned = uns; addr = a; store_data = sd;
    start = 1'b1;
    nreq = 0;
    acc = 1'b0;
    lat_obs = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = restart && cyc == 2;
      if (restart && cyc == 2) begin is_load = 1'b0; is_store = 1'b1; addr = 32'h0000_7770; end
      dif.dmem_rvalid = (acc && ld) || (spur && cyc == 1);
      dif.dmem_rdata = acc ? rd : 32'hDEAD_BEEF;
      acc = 1'b0;
      if (dif.dmem_req) begin
        nreq++;
        chk({tag, "_addr"}, dif.dmem_addr, e.daddr);
        chk({tag, "_we"}, 32'(dif.dmem_we), 32'(e.we));
        chk({tag, "_wstrb"}, 32'(dif.dmem_wstrb), 32'(e.wstrb));
        if (e.we) chk({tag, "_wdata"}, dif.dmem_wdata, e.wdata);
        dif.dmem_ready = nreq > rdy_dly;
        acc = dif.dmem_ready;
      end else dif.dmem_ready = 1'b0;
      if (done) begin lat_obs = cyc; break; end
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    g = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat_obs), 32'(g.lat));
    chk({tag, "_mis"}, 32'(misaligned), 32'(g.mis));
    chk({tag, "_ld"}, load_data, g.ld);
    chk({tag, "_reqseen"}, 32'(nreq > 0), 32'(g.req));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    dif.dmem_ready = 1'b0; dif.dmem_rvalid = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_nodone"}, {30'b0, done, misaligned}, 32'd0);
    end
  endtask
  initial begin
    dif.dmem_ready = 1'b0; dif.dmem_rvalid = 1'b0; dif.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", {26'b0, busy, done, misaligned, dif.dmem_req, dif.dmem_we, 1'b0}, 32'd0);
    chk("rst_wstrb", 32'(dif.dmem_wstrb), 32'd0);
    chk("rst_ld", load_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op("st_b",   0, 1, 2'b00, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 0);
    run_op("ld_hs",  1, 0, 2'b01, 0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 0);
    run_op("ld_hu",  1, 0, 2'b01, 1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 0);
    run_op("ld_wst", 1, 0, 2'b10, 0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 5, 1, 0);
    run_op("ld_mis", 1, 0, 2'b10, 0, 32'h0000_2001, 32'h0, 32'h1111_1111, 0, 0, 0);
    run_op("st_h",   0, 1, 2'b01, 0, 32'h0000_4002, 32'h1234_ABCD, 32'h0, 0, 0, 0);
    run_op("st_w",   0, 1, 2'b10, 0, 32'h0000_4000, 32'h1122_3344, 32'h0, 2, 0, 0);
    run_op("ld_bs",  1, 0, 2'b00, 0, 32'h0000_5001, 32'h0, 32'h0000_8000, 0, 0, 0);
    run_op("ld_bu",  1, 0, 2'b00, 1, 32'h0000_5003, 32'h0, 32'hA500_0000, 1, 0, 0);
    run_op("pass",   0, 0, 2'b10, 0, 32'h0000_6003, 32'h0, 32'h0, 0, 0, 0);
    run_op("st_mis", 0, 1, 2'b01, 0, 32'h0000_4001, 32'h5555_5555, 32'h0, 0, 0, 0);
    run_op("ld_rst", 1, 0, 2'b10, 0, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 0, 0, 1);
    run_op("st_w11", 0, 1, 2'b11, 0, 32'h0000_7000, 32'h89AB_CDEF, 32'h0, 0, 0, 0);
    is_load = 1'b1; is_store = 1'b0; mem_width = 2'b10; addr = 32'h0000_7004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rr_req", 32'(dif.dmem_req), 32'd1);
    dif.dmem_ready = 1'b1;
    @(negedge clk);
    dif.dmem_ready = 1'b0;
    chk("rr_resp_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_out", {26'b0, busy, done, misaligned, dif.dmem_req, dif.dmem_we, 1'b0}, 32'd0);
    chk("rr_addr", dif.dmem_addr, 32'd0);
    chk("rr_wdata", dif.dmem_wdata, 32'd0);
    chk("rr_wstrb", 32'(dif.dmem_wstrb), 32'd0);
    chk("rr_ld", load_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dif.dmem_rvalid = 1'b1; dif.dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    dif.dmem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_nodone", {30'b0, done, busy}, 32'd0);
      chk("rr_ld_held", load_data, 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
